// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add 32x32 multiplier (RV32M MUL/MULH/MULHSU/MULHU).
// Optional macro MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier is zero.
module mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [1:0]       func,
  input  logic             en,
  output logic [WIDTH-1:0] res,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic [1:0]         func_q;

  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] step, prod;
  logic               last;

  // MULHU treats both operands as unsigned, MULHSU only opB
  assign sgn_a = (func != 2'd3) && opA[WIDTH-1];
  assign sgn_b = !func[1] && opB[WIDTH-1];
  assign mag_a = sgn_a ? (~opA + 1'b1) : opA;
  assign mag_b = sgn_b ? (~opB + 1'b1) : opB;

  // Carry out of the upper-half add is shifted back in as the new MSB
  assign sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
  assign step = {sum, acc[WIDTH-1:1]};
  assign prod = neg ? (~acc + 1'b1) : acc;
  assign last = (cnt == CNT_W'(WIDTH - 1));

`ifdef MUL_EARLY_EXIT_EN
  logic           mp_zero;
  logic [CNT_W:0] shamt;
  assign mp_zero = (mplier == '0);
  assign shamt   = (CNT_W+1)'(WIDTH) - {1'b0, cnt};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = CALC;
`ifdef MUL_EARLY_EXIT_EN
      CALC: if (mp_zero || last) state_nxt = FIN;
`else
      CALC: if (last) state_nxt = FIN;
`endif
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      func_q <= '0;
      res    <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= '0;
            neg    <= sgn_a ^ sgn_b;
            func_q <= func;
            busy   <= 1'b1;
          end
        end
        CALC: begin
`ifdef MUL_EARLY_EXIT_EN
          // Remaining iterations would only shift; do them all at once
          if (mp_zero) begin
            acc <= acc >> shamt;
          end else begin
            acc    <= step;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
          end
`else
          acc    <= step;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
`endif
        end
        FIN: begin
          res  <= (func_q == 2'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed RV32M cases, handshake corner cases,
// mid-operation reset and randomized vectors against a 64-bit arithmetic model.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] opA, opB;
  logic [1:0]  func;
  logic        en;
  logic [31:0] res;
  logic        done, busy;

  int checks = 0;
  int errors = 0;

  mul_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .opA(opA), .opB(opB), .func(func),
    .en(en), .res(res), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
    logic [63:0] x, y, p;
    x = (f != 2'd3) ? {{32{a[31]}}, a} : {32'b0, a};
    y = (f < 2'd2)  ? {{32{b[31]}}, b} : {32'b0, b};
    p = x * y;
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(input logic [31:0] b, input logic [1:0] f);
`ifdef MUL_EARLY_EXIT_EN
    logic [31:0] m;
    int          len;
    m = (f < 2'd2 && b[31]) ? (0 - b) : b;
    len = 0;
    for (int i = 0; i < 32; i++) if (m[i]) len = i + 1;
    return (2 + len > 33) ? 33 : 2 + len;
`else
    return 33;
`endif
  endfunction

  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
    @(negedge clk);
    opA = a; opB = b; func = f; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  // Starts an op, optionally pulses a spurious en after edge inj, waits for done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                        input int inj, output int lat, output logic [31:0] r);
    start(a, b, f);
    chk("busy_after_accept", busy, 1'b1);
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == inj) begin
        opA = 32'h1234_5678; opB = 32'h9ABC_DEF0; func = 2'd3; en = 1'b1;
      end
      @(posedge clk); #1;
      en = 1'b0;
      lat++;
    end
    r = res;
    chk("done_timeout", done, 1'b1);
    chk("busy_at_done", busy, 1'b0);
  endtask

  logic [31:0] da [10] = '{32'hFFF0_BDC0, 32'hFFF0_BDC0, 32'h0000_550B, 32'h0000_550B, 32'h0000_550B,
                           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] db [10] = '{32'd168, 32'd168, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
  logic [1:0]  df [10] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd1, 2'd1, 2'd0};
  logic [31:0] dr [10] = '{32'hF5FC_8600, 32'hFFFF_FFFF, 32'hFFFF_AAF5, 32'hFFFF_FFFF, 32'h0000_550A,
                           32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h4000_0000, 32'h0000_0000};

  initial begin
    int          lat;
    logic [31:0] r, a, b;
    logic [1:0]  f;
    logic        seen;

    rst = 1'b1; en = 1'b0; opA = '0; opB = '0; func = '0;
    repeat (20) @(posedge clk);
    #1;
    chk("reset_res", res, 32'h0);
    chk("reset_done", done, 1'b0);
    chk("reset_busy", busy, 1'b0);
    @(negedge clk); rst = 1'b0;

    // Directed vectors; each accepted in the done cycle of the previous one
    for (int i = 0; i < 10; i++) begin
      run_op(da[i], db[i], df[i], -1, lat, r);
      chk($sformatf("dir_res_%0d", i), r, dr[i]);
      chk($sformatf("dir_lat_%0d", i), lat, exp_lat(db[i], df[i]));
    end
    @(posedge clk); #1;
    chk("done_falls", done, 1'b0);

    // Spurious en while busy must be ignored
    run_op(32'hFFF0_BDC0, 32'd168, 2'd0, 10, lat, r);
    chk("ign_res", r, 32'hF5FC_8600);
    chk("ign_lat", lat, exp_lat(32'd168, 2'd0));
    @(posedge clk); #1;
    chk("ign_no_second_done", done, 1'b0);
    chk("ign_not_busy", busy, 1'b0);

    // Accept in the done cycle, then check the second op's latency
    run_op(32'h0000_0007, 32'h8765_4321, 2'd3, -1, lat, r);
    chk("b2b_first_res", r, model(32'h0000_0007, 32'h8765_4321, 2'd3));
    chk("b2b_done_at_accept", done, 1'b1);
    run_op(32'hDEAD_BEEF, 32'hF000_0001, 2'd3, -1, lat, r);
    chk("b2b_second_res", r, model(32'hDEAD_BEEF, 32'hF000_0001, 2'd3));
    chk("b2b_second_lat", lat, 33);

    // Reset during an operation aborts it with no done
    start(32'h1357_9BDF, 32'hFFFF_FFFF, 2'd3);
    repeat (14) @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("midrst_res", res, 32'h0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    chk("midrst_no_done", seen, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 2'd0, -1, lat, r);
    chk("postrst_res", r, 32'h0);
    chk("postrst_lat", lat, exp_lat(32'h8000_0000, 2'd0));

    // Randomized vectors with occasional corner operands
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom; f = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = b >> $urandom_range(0, 31);
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(a, b, f, -1, lat, r);
      chk($sformatf("rnd_res_%0d", i), r, model(a, b, f));
      chk($sformatf("rnd_lat_%0d", i), lat, exp_lat(b, f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Iterative 32x32 multiplier; companion to the sequential divider in the execute-stage M-extension datapath.
- Shares the divider's operand/handshake style: one-cycle `en` pulse launches an operation; result plus one-cycle `done` pulse on completion.
- Radix-2 shift-add on operand magnitudes, then sign fix-up.
- Returns the low or high 32 bits of the 64-bit product, selected by `func` (RV32M MUL/MULH/MULHSU/MULHU).

Parameters:
- WIDTH, 32, operand and result width; the product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk   input   1      rising-edge clock
- rst   input   1      asynchronous active-high reset
- opA   input   WIDTH  multiplicand; sampled only when en=1 in IDLE
- opB   input   WIDTH  multiplier; sampled only when en=1 in IDLE
- func  input   2      0=MUL (low, signed x signed), 1=MULH (high, s x s), 2=MULHSU (high, opA signed x opB unsigned), 3=MULHU (high, u x u); sampled with opA/opB
- en    input   1      start request; single-cycle pulse
- res   output  WIDTH  result; holds its value until the next completion
- done  output  1      one-cycle completion pulse
- busy  output  1      high from the accept edge until the edge that raises done

Behaviour:
- Reset (async, rst=1): state=IDLE; res=0; done=0; busy=0; all internal registers (counter, accumulator, operand copies) cleared. A reset mid-operation aborts it with no done pulse.
- States: IDLE, CALC, FIN.
- IDLE, accept edge (edge 0, en=1):
  - Capture |opA| and |opB|. Each operand is treated as signed per func; otherwise its raw value is used.
  - Capture neg = signA XOR signB, func, and cnt=0.
  - Set busy=1 and go to CALC.
  - In IDLE with en=0: hold.
- CALC, one iteration per edge:
  - If mplier[0]=1, add mcand into the upper half of the 64-bit accumulator.
  - Then shift accumulator and mplier right by 1 and increment cnt.
  - After the iteration with cnt=WIDTH-1 (edge 32), go to FIN.
- FIN (edge 33):
  - prod = neg ? two's-complement negate of the 64-bit accumulator : accumulator.
  - res = func==0 ? prod[31:0] : prod[63:32].
  - done=1, busy=0, state=IDLE.
- done falls at edge 34 unless it is re-raised.
- Latency: done is high in the 34th cycle after the accept edge (edge 33). Throughput: one operation per 34 cycles.
- en while busy=1 (CALC/FIN): ignored; no queuing; operands are not resampled.
- en in the cycle done=1: accepted, because state is already IDLE.
- Magnitude of 0x8000_0000 (signed): 0x8000_0000 as unsigned, so the MIN x MIN product is correct without overflow logic.
- res and done change only on clock edges; no combinational input-to-output path.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined: in CALC, if the remaining mplier is 0 at an edge, skip the iteration and go straight to FIN.
  - The accumulator is then right-aligned by shifting the remaining (WIDTH - cnt) positions in a single step using the barrel shift.
  - Latency becomes 2 + bitlength(|opB|) edges to done; |opB|=0 gives done at edge 2.
  - Results are bit-identical to the undefined build.
- Undefined: fixed 33-edge latency as above; no barrel shifter.

Test Plan:
- Reset 20 cycles, release; en=1 one cycle, opA=0xFFF0_BDC0, opB=168 (0xA8), func=0 -> done exactly at edge 33 (fixed build), res=0xF5FC_8600; repeat with func=1 -> res=0xFFFF_FFFF.
- opA=0x0000_550B, opB=0xFFFF_FFFF: func=0 -> 0xFFFF_AAF5; func=1 -> 0xFFFF_FFFF; func=3 -> 0x0000_550A.
- opA=opB=0xFFFF_FFFF: func=3 -> 0xFFFF_FFFE; func=2 -> 0xFFFF_FFFF; func=1 -> 0x0000_0000. opA=opB=0x8000_0000, func=1 -> 0x4000_0000.
- Pulse en again at edge 10 with different operands -> ignored; first result unchanged. en asserted in the done cycle -> second op accepted; its done arrives 33 edges later.
- Assert rst at edge 15 of an operation -> res=0, busy=0 immediately; no done pulse; next operation completes normally.
- With MUL_EARLY_EXIT_EN: opB=0 -> done at edge 2, res=0; opB=168 (8 bits) -> done at edge 10, res as in scenario 1; random 1000-vector compare against a 64-bit reference model for all func values.
